// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port with
// same-cycle bypass, and a saturating per-register pending-write scoreboard.
module regfile_scoreboard #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic             claim_stall,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  output logic             rd_busy0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_busy1,
  output logic             err_underflow
);

  localparam int NREGS = 2 ** AW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0][CW-1:0]    cnt;
  logic [NREGS-1:0]            wr_hit;
  logic [NREGS-1:0]            claim_hit;
  logic [NREGS-1:0]            uf_evt;
  logic                        claim_ok;

  // A retiring write to the claimed register frees a slot in the same cycle.
  always_comb begin
    claim_stall = claim_en && (cnt[claim_addr] == CNT_MAX) &&
                  !(wr_en && (wr_addr == claim_addr));
    claim_ok    = claim_en && !claim_stall;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    assign wr_hit[i]    = wr_en && (wr_addr == AW'(i));
    assign claim_hit[i] = claim_ok && (claim_addr == AW'(i));
    assign uf_evt[i]    = wr_hit[i] && !claim_hit[i] && (cnt[i] == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end else begin
        if (wr_hit[i]) regs[i] <= wr_data;
        case ({claim_hit[i], wr_hit[i]})
          2'b10:   if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CW'(1);
          2'b01:   if (cnt[i] != '0)      cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Busy reflects the count after this cycle's retirement; claims do not count yet.
  function automatic logic busy_of(input logic [CW-1:0] c, input logic retiring);
    return retiring ? (c > CW'(1)) : (c != '0);
  endfunction

  always_comb begin
    rd_data0 = (wr_en && (wr_addr == rd_addr0)) ? wr_data : regs[rd_addr0];
    rd_data1 = (wr_en && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
    rd_busy0 = busy_of(cnt[rd_addr0], wr_en && (wr_addr == rd_addr0));
    rd_busy1 = busy_of(cnt[rd_addr1], wr_en && (wr_addr == rd_addr1));
  end

  always_ff @(posedge clk) begin
    if (reset)        err_underflow <= 1'b0;
    else if (|uf_evt) err_underflow <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of bypass, scoreboard counting/saturation, underflow and reset.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        claim_en;
  logic [2:0]  claim_addr;
  logic        claim_stall;
  logic [2:0]  rd_addr0, rd_addr1;
  logic [15:0] rd_data0, rd_data1;
  logic        rd_busy0, rd_busy1;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard #(.WIDTH(16), .AW(3), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_stall(claim_stall),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_busy0(rd_busy0),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic claim(input logic [2:0] a);
    claim_en = 1'b1; claim_addr = a;
  endtask

  initial begin
    idle(); rd_addr0 = '0; rd_addr1 = '0;
    reset = 1'b1;
    tick(); tick();
    idle();
    #1;
    chk("init_uf", err_underflow, 1'b0);

    // Preload every register (unclaimed writes -> underflow), claim R4/R6
    for (int r = 0; r < 8; r++) begin
      idle(); wr(3'(r), 16'h1000 + 16'(r)); tick();
    end
    idle(); claim(3'd4); tick();
    idle(); claim(3'd6); tick();
    idle(); rd_addr0 = 3'd4; rd_addr1 = 3'd6; #1;
    chk("pre_rd0", rd_data0, 16'h1004);
    chk("pre_busy0", rd_busy0, 1'b1);
    chk("pre_busy1", rd_busy1, 1'b1);
    chk("pre_uf", err_underflow, 1'b1);

    reset = 1'b1; tick(); idle();
    for (int r = 0; r < 8; r++) begin
      rd_addr0 = 3'(r); rd_addr1 = 3'(7 - r); #1;
      chk("rst_rd0", rd_data0, 16'h0000);
      chk("rst_rd1", rd_data1, 16'h0000);
      chk("rst_busy0", rd_busy0, 1'b0);
      chk("rst_busy1", rd_busy1, 1'b0);
    end
    chk("rst_uf", err_underflow, 1'b0);

    // Bypass on both ports, then storage
    idle(); claim(3'd3); tick();
    idle(); rd_addr0 = 3'd3; rd_addr1 = 3'd3; #1;
    chk("r3_before", rd_data0, 16'h0000);
    chk("r3_busy", rd_busy0, 1'b1);
    wr(3'd3, 16'hBEEF); #1;
    chk("byp_rd0", rd_data0, 16'hBEEF);
    chk("byp_rd1", rd_data1, 16'hBEEF);
    chk("byp_busy0", rd_busy0, 1'b0);
    tick(); idle(); #1;
    chk("stored_rd0", rd_data0, 16'hBEEF);
    chk("stored_busy", rd_busy0, 1'b0);
    chk("byp_uf", err_underflow, 1'b0);

    // Saturation on R5
    rd_addr1 = 3'd5;
    for (int k = 0; k < 3; k++) begin
      idle(); claim(3'd5); #1;
      chk("claim5_stall", claim_stall, 1'b0);
      tick();
    end
    idle(); #1;
    chk("r5_busy", rd_busy1, 1'b1);
    chk("stall_noen", claim_stall, 1'b0);
    claim(3'd5); #1;
    chk("claim5_full", claim_stall, 1'b1);
    tick();
    idle(); claim(3'd5); wr(3'd5, 16'h5555); #1;
    chk("claim5_wr_stall", claim_stall, 1'b0);
    chk("claim5_wr_busy", rd_busy1, 1'b1);
    chk("claim5_wr_byp", rd_data1, 16'h5555);
    tick();
    // Count must still be 3: two writes keep busy, third clears it without underflow
    idle(); wr(3'd5, 16'h0001); #1; chk("r5_drain1", rd_busy1, 1'b1); tick();
    idle(); wr(3'd5, 16'h0002); #1; chk("r5_drain2", rd_busy1, 1'b1); tick();
    idle(); wr(3'd5, 16'h0003); #1; chk("r5_drain3", rd_busy1, 1'b0); tick();
    idle(); #1;
    chk("r5_data", rd_data1, 16'h0003);
    chk("r5_uf", err_underflow, 1'b0);

    // Single claim of R2 then retire; claim R6 and retire R4 together
    idle(); claim(3'd2); tick();
    idle(); claim(3'd4); rd_addr0 = 3'd2; #1;
    chk("r2_busy", rd_busy0, 1'b1);
    tick();
    idle(); wr(3'd2, 16'h1234); claim(3'd6); #1;
    chk("r2_wr_busy", rd_busy0, 1'b0);
    chk("r2_wr_data", rd_data0, 16'h1234);
    tick();
    idle(); wr(3'd4, 16'h4444); claim(3'd6); rd_addr0 = 3'd4; rd_addr1 = 3'd6; #1;
    chk("r4_wr_busy", rd_busy0, 1'b0);
    chk("r6_busy_now", rd_busy1, 1'b1);
    tick();
    idle(); #1;
    chk("r4_busy_after", rd_busy0, 1'b0);
    chk("r4_data", rd_data0, 16'h4444);
    wr(3'd6, 16'h6666); #1;
    chk("r6_cnt2", rd_busy1, 1'b1);
    tick();
    idle(); wr(3'd6, 16'h6667); #1;
    chk("r6_cnt1", rd_busy1, 1'b0);
    tick();
    idle(); #1;
    chk("mix_uf", err_underflow, 1'b0);

    // Underflow on R7 is sticky
    wr(3'd7, 16'h7777); tick();
    idle(); rd_addr0 = 3'd7; #1;
    chk("r7_data", rd_data0, 16'h7777);
    chk("r7_uf", err_underflow, 1'b1);
    claim(3'd0); tick();
    idle(); wr(3'd0, 16'h0A0A); tick();
    idle(); #1;
    chk("uf_sticky", err_underflow, 1'b1);

    // Reset beats a same-cycle write and claim on R1
    claim(3'd1); tick();
    idle(); rd_addr0 = 3'd1; #1;
    chk("r1_busy_pre", rd_busy0, 1'b1);
    reset = 1'b1; wr(3'd1, 16'hFFFF); claim(3'd1); tick();
    idle(); #1;
    chk("r1_rst_data", rd_data0, 16'h0000);
    chk("r1_rst_busy", rd_busy0, 1'b0);
    chk("r1_rst_uf", err_underflow, 1'b0);
    claim(3'd1); tick();
    idle(); wr(3'd1, 16'h1111); #1;
    chk("r1_cnt_was0", rd_busy0, 1'b0);
    tick();
    idle(); #1;
    chk("r1_final_uf", err_underflow, 1'b0);
    chk("r1_final_data", rd_data0, 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined LC-3 datapath. Two asynchronous read ports and one synchronous write port, with same-cycle write-to-read bypass. Per-register pending-write scoreboard lets decode stall on RAW hazards. Replaces the fixed 8x16 file with decoder and mux slices; the register and bypass state sits between the decode and writeback stages.

Parameters:
WIDTH, 16, data width of each register in bits
AW, 3, register address width; number of registers NREGS = 2**AW
CW, 2, pending-count width; max outstanding writes per register = 2**CW - 1

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination register
wr_data  in  WIDTH  writeback data
claim_en  in  1  issue strobe: instruction reserving a destination
claim_addr  in  AW  register being reserved
claim_stall  out  1  claim cannot be accepted this cycle (combinational)
rd_addr0  in  AW  read port 0 address (SR1)
rd_data0  out  WIDTH  read port 0 data (combinational)
rd_busy0  out  1  register on port 0 has an outstanding write
rd_addr1  in  AW  read port 1 address (SR2)
rd_data1  out  WIDTH  read port 1 data (combinational)
rd_busy1  out  1  register on port 1 has an outstanding write
err_underflow  out  1  sticky: write retired to a register with pending count 0

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). On the reset edge: all registers = 0, all pending counts = 0, err_underflow = 0. Reset has priority over wr_en and claim_en in the same cycle; an in-flight claim or write is discarded.
- Write: on a clk edge with wr_en = 1, reg[wr_addr] <= wr_data. Write latency is 1 cycle to storage.
- Read: rd_dataN = reg[rd_addrN], combinational.
- Bypass: if wr_en = 1 and wr_addr == rd_addrN, rd_dataN = wr_data in the same cycle. Both ports bypass independently.
- Scoreboard: each register has a CW-bit pending count cnt[r].
  - Accepted claim (claim_en = 1 and claim_stall = 0): cnt[claim_addr] + 1.
  - Write: cnt[wr_addr] - 1.
  - Claim and write to the same register in the same cycle: count unchanged.
  - Claim and write to different registers: both updates apply.
- claim_stall = claim_en and cnt[claim_addr] == 2**CW - 1 and not (wr_en and wr_addr == claim_addr). A stalled claim leaves the count unchanged.
- rd_busyN = effective count != 0, where effective count = cnt[rd_addrN] minus 1 if a write to that register retires this cycle. A claim in the same cycle does not affect rd_busyN.
- Underflow: a write with cnt[wr_addr] == 0 (and no same-cycle claim to that register) still updates the data. The count stays 0, and err_underflow sets and holds until reset.
- Counts saturate; they never wrap in either direction.
- No read-after-write ordering constraint exists between ports; both ports may address the same register.

Test Plan:
- Reset with every register preloaded -> every rd_data = 0x0000, every busy = 0, err_underflow = 0 on the next cycle.
- Write R3 = 0xBEEF with rd_addr0 = 3 in the same cycle -> rd_data0 = 0xBEEF that cycle (bypass). With wr_en = 0 on the following cycle -> still 0xBEEF.
- Claim R5 three times (CW = 2) -> rd_busy1 = 1 on rd_addr1 = 5. Fourth claim -> claim_stall = 1 and count stays 3. Same fourth claim plus a write to R5 -> claim_stall = 0 and count stays 3.
- Single claim of R2, then write R2 = 0x1234 with rd_addr0 = 2 -> rd_busy0 = 0 and rd_data0 = 0x1234 in the write cycle.
- Write R7 with no prior claim -> R7 updated, err_underflow = 1 and stays 1 across later traffic until reset.
- Assert reset in the same cycle as a write to R1 and a claim of R1 -> R1 = 0, count = 0, rd_busy = 0 afterwards.
